// File: rtl/sram_like_resp.sv
// sram_like_resp
// Responder (slave) side of the CPU sram-like bus. It is backed by a local
// memory of 2^ADDR_W 32-bit words. Requests are accepted in a pipelined way
// and queued in order. Each response (data_ok/rdata) is returned no earlier
// than LAT cycles after its address handshake.
//
// Ports
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset (control state only; memory persists)
//   req          request valid
//   wr           1 = write, 0 = read
//   size         transfer size (informational; wstrb is authoritative)
//   wstrb        byte write enables, bit i -> wdata[8i+7:8i]
//   addr         byte address (addr[ADDR_W+1:2] selects the word, other bits ignored)
//   wdata        write data
//   addr_stall   test backpressure, forces addr_ok low
//   resp_stall   test backpressure, holds back data_ok
//   addr_ok      request accepted this cycle when req && addr_ok
//   data_ok      response for the oldest outstanding request
//   rdata        read data when data_ok on a read, otherwise 0
//   outstanding  current queue occupancy (0..DEPTH)
module sram_like_resp #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4,
  parameter int LAT    = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     req,
  input  logic                     wr,
  input  logic [1:0]               size,
  input  logic [3:0]               wstrb,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  input  logic                     addr_stall,
  input  logic                     resp_stall,
  output logic                     addr_ok,
  output logic                     data_ok,
  output logic [31:0]              rdata,
  output logic [$clog2(DEPTH):0]   outstanding
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = (LAT < 2) ? 1 : $clog2(LAT + 1);

  logic [31:0]       r_mem    [2**ADDR_W];

  logic              r_q_vld  [DEPTH];
  logic [AW-1:0]     r_q_age  [DEPTH];
  logic              r_q_wr   [DEPTH];
  logic [31:0]       r_q_data [DEPTH];

  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_rd_snap;
  logic              w_head_rdy;

  // size and the alias/byte-offset address bits carry no meaning here.
  logic              w_unused;
  assign w_unused = &{1'b0, size, addr[31:ADDR_W+2], addr[1:0]};

  // Request side: handshake, word index and read snapshot (pre-write value)
  // Fullness uses only the registered count; a retire in the same cycle
  // does not open a slot until the next cycle.
  assign w_full    = (r_count == CW'(DEPTH));
  assign addr_ok   = req && !addr_stall && !w_full;
  assign w_push    = req && addr_ok;
  assign w_idx     = addr[ADDR_W+1:2];
  assign w_rd_snap = r_mem[w_idx];

  // Response side: head becomes eligible once it has aged LAT cycles
  assign w_head_rdy  = r_q_vld[r_rptr] && (r_q_age[r_rptr] >= AW'(LAT));
  assign data_ok     = w_head_rdy && !resp_stall;
  assign w_pop       = data_ok;
  assign rdata       = (data_ok && !r_q_wr[r_rptr]) ? r_q_data[r_rptr] : 32'h0;
  assign outstanding = r_count;

  // Queue control state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_vld[i] <= 1'b0;
        r_q_age[i] <= '0;
      end
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // Push and pop never target the same slot: push needs count<DEPTH,
      // pop needs count>0, so the pointers differ whenever both fire.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (r_wptr == PW'(i))) begin
          r_q_vld[i] <= 1'b1;
          r_q_age[i] <= AW'(1);
        end else if (w_pop && (r_rptr == PW'(i))) begin
          r_q_vld[i] <= 1'b0;
          r_q_age[i] <= '0;
        end else if (r_q_vld[i] && (r_q_age[i] < AW'(LAT))) begin
          r_q_age[i] <= r_q_age[i] + AW'(1);
        end
      end
    end
  end

  // Queue payload and memory array (no reset: contents survive resetn)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_wr[r_wptr]   <= wr;
      r_q_data[r_wptr] <= w_rd_snap;
      for (int b = 0; b < 4; b++) begin
        if (wr && wstrb[b]) r_mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule
